// File: rtl/boundary_cell_piv.sv
// boundary_cell_piv
//   Diagonal cell of the triangularization systolic array. For each accepted
//   element x it keeps the pivot p, decides the neighbour-pivoting swap s and
//   computes the row multiplier c = -num/den with a bit-serial restoring
//   divider. Results are announced by a one-cycle c_valid pulse.
// Parameters
//   DW    data width, two's complement fixed point
//   FRAC  fractional bits
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active low
//   operation  1 = neighbour pivoting, 0 = non-pivoting (sampled on accept)
//   load       with x_valid: x becomes the new pivot, no division
//   x_in       incoming element
//   x_valid    x_in/load/operation valid
//   x_ready    cell idle and able to accept
//   c_out      multiplier for the row's first internal cell
//   s_out      swap flag for the row's first internal cell
//   c_valid    one-cycle pulse, c_out/s_out new this cycle
//   p_out      current pivot register
//   div_zero   sticky divide-by-zero flag, cleared by load or reset
module boundary_cell_piv #(
  parameter int DW   = 32,
  parameter int FRAC = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          operation,
  input  logic          load,
  input  logic [DW-1:0] x_in,
  input  logic          x_valid,
  output logic          x_ready,
  output logic [DW-1:0] c_out,
  output logic          s_out,
  output logic          c_valid,
  output logic [DW-1:0] p_out,
  output logic          div_zero
);

  localparam int QW = DW + FRAC;
  localparam int CW = $clog2(QW + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DIV  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CW-1:0] CNT_LAST = CW'(QW);
  localparam logic [DW-1:0] C_MAX    = {1'b0, {(DW-1){1'b1}}};
  localparam logic [QW-1:0] Q_MAX    = {{(FRAC+1){1'b0}}, {(DW-1){1'b1}}};

  logic [1:0]    state_q, state_d;
  logic [DW-1:0] p_q, p_d;
  logic [DW-1:0] c_out_q, c_out_d;
  logic          s_out_q, s_out_d;
  logic          c_valid_q, c_valid_d;
  logic          div_zero_q, div_zero_d;
  // Result staged until the DONE cycle publishes it.
  logic [DW-1:0] res_q, res_d;
  logic          s_pend_q, s_pend_d;
  logic          dz_set_q, dz_set_d;
  logic          dz_clr_q, dz_clr_d;
  logic          neg_q, neg_d;
  logic [DW-1:0] den_q, den_d;
  logic [DW-1:0] rem_q, rem_d;
  logic [QW-1:0] dvd_q, dvd_d;
  logic [QW-1:0] quo_q, quo_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          accept;
  logic [DW-1:0] abs_x, abs_p, abs_num, abs_den;
  logic          swap;
  logic [DW:0]   rem_sh, rem_sub;
  logic          q_bit;
  logic [DW-1:0] c_mag;

  always_comb begin
    accept  = x_valid && (state_q == ST_IDLE);
    abs_x   = x_in[DW-1] ? -x_in : x_in;
    abs_p   = p_q[DW-1]  ? -p_q  : p_q;
    swap    = operation && (abs_x > abs_p);
    abs_num = swap ? abs_p : abs_x;
    abs_den = swap ? abs_x : abs_p;

    // One restoring step: borrow out of the trial subtract decides the bit.
    rem_sh  = {rem_q, dvd_q[QW-1]};
    rem_sub = rem_sh - {1'b0, den_q};
    q_bit   = ~rem_sub[DW];
    c_mag   = (quo_q > Q_MAX) ? C_MAX : quo_q[DW-1:0];

    state_d    = state_q;
    p_d        = p_q;
    c_out_d    = c_out_q;
    s_out_d    = s_out_q;
    c_valid_d  = (state_q == ST_DONE);
    div_zero_d = div_zero_q;
    res_d      = res_q;
    s_pend_d   = s_pend_q;
    dz_set_d   = dz_set_q;
    dz_clr_d   = dz_clr_q;
    neg_d      = neg_q;
    den_d      = den_q;
    rem_d      = rem_q;
    dvd_d      = dvd_q;
    quo_d      = quo_q;
    cnt_d      = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (load) begin
            p_d      = x_in;
            res_d    = '0;
            s_pend_d = 1'b0;
            dz_set_d = 1'b0;
            dz_clr_d = 1'b1;
            state_d  = ST_DONE;
          end else begin
            s_pend_d = swap;
            dz_clr_d = 1'b0;
            // sign(num)^sign(den) is the same whichever operand is the divisor
            neg_d    = x_in[DW-1] ^ p_q[DW-1];
            if (swap) p_d = x_in;
            if (abs_den == '0) begin
              res_d    = '0;
              dz_set_d = 1'b1;
              state_d  = ST_DONE;
            end else begin
              dz_set_d = 1'b0;
              den_d    = abs_den;
              dvd_d    = {abs_num, {FRAC{1'b0}}};
              rem_d    = '0;
              quo_d    = '0;
              cnt_d    = '0;
              state_d  = ST_DIV;
            end
          end
        end
      end
      ST_DIV: begin
        if (cnt_q == CNT_LAST) begin
          res_d   = neg_q ? c_mag : -c_mag;
          state_d = ST_DONE;
        end else begin
          rem_d = q_bit ? rem_sub[DW-1:0] : rem_sh[DW-1:0];
          dvd_d = {dvd_q[QW-2:0], 1'b0};
          quo_d = {quo_q[QW-2:0], q_bit};
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        c_out_d    = res_q;
        s_out_d    = s_pend_q;
        div_zero_d = dz_clr_q ? 1'b0 : (dz_set_q ? 1'b1 : div_zero_q);
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      p_q        <= '0;
      c_out_q    <= '0;
      s_out_q    <= 1'b0;
      c_valid_q  <= 1'b0;
      div_zero_q <= 1'b0;
      res_q      <= '0;
      s_pend_q   <= 1'b0;
      dz_set_q   <= 1'b0;
      dz_clr_q   <= 1'b0;
      neg_q      <= 1'b0;
      den_q      <= '0;
      rem_q      <= '0;
      dvd_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      p_q        <= p_d;
      c_out_q    <= c_out_d;
      s_out_q    <= s_out_d;
      c_valid_q  <= c_valid_d;
      div_zero_q <= div_zero_d;
      res_q      <= res_d;
      s_pend_q   <= s_pend_d;
      dz_set_q   <= dz_set_d;
      dz_clr_q   <= dz_clr_d;
      neg_q      <= neg_d;
      den_q      <= den_d;
      rem_q      <= rem_d;
      dvd_q      <= dvd_d;
      quo_q      <= quo_d;
      cnt_q      <= cnt_d;
    end
  end

  assign x_ready  = (state_q == ST_IDLE);
  assign c_out    = c_out_q;
  assign s_out    = s_out_q;
  assign c_valid  = c_valid_q;
  assign p_out    = p_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_boundary_cell_piv.sv
// Bench for boundary_cell_piv at Q16.16: table of directed vectors plus a
// reset-abort sequence and a short randomized run, all checked through a
// scoreboard popped on each c_valid pulse.
module tb_boundary_cell_piv;
  localparam int DW   = 32;
  localparam int FRAC = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          operation = 1'b0;
  logic          load = 1'b0;
  logic [DW-1:0] x_in = '0;
  logic          x_valid = 1'b0;
  logic          x_ready;
  logic [DW-1:0] c_out;
  logic          s_out;
  logic          c_valid;
  logic [DW-1:0] p_out;
  logic          div_zero;

  boundary_cell_piv #(.DW(DW), .FRAC(FRAC)) dut (
    .clk(clk), .rst(rst), .operation(operation), .load(load),
    .x_in(x_in), .x_valid(x_valid), .x_ready(x_ready),
    .c_out(c_out), .s_out(s_out), .c_valid(c_valid),
    .p_out(p_out), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic        op;
    logic [31:0] x;
    logic [31:0] c;
    logic        s;
    logic [31:0] p;
    logic        dz;
    int          lat;
  } vec_t;

  typedef struct {
    vec_t v;
    int   acc;
  } sb_t;

  sb_t         sb[$];
  vec_t        tbl[$];
  sb_t         mon_e;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          pulses = 0;
  logic [31:0] m_p = '0;
  logic        m_dz = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic vec_t mk(input logic ld, input logic op, input logic [31:0] x,
                              input logic [31:0] c, input logic s, input logic [31:0] p,
                              input logic dz, input int lat);
    vec_t v;
    v.ld = ld; v.op = op; v.x = x; v.c = c; v.s = s; v.p = p; v.dz = dz; v.lat = lat;
    return v;
  endfunction

  // Reference: c = -num/den in Q16.16 using wide integer division.
  function automatic void model(input logic ld, input logic op, input logic [31:0] x, output vec_t v);
    longint unsigned ax, ap, an, ad, q;
    logic sw, neg;
    v.ld = ld; v.op = op; v.x = x;
    if (ld) begin
      m_p = x; m_dz = 1'b0; v.c = '0; v.s = 1'b0; v.lat = 1;
    end else begin
      ax  = x[31]   ? (64'h1_0000_0000 - {32'b0, x})   : {32'b0, x};
      ap  = m_p[31] ? (64'h1_0000_0000 - {32'b0, m_p}) : {32'b0, m_p};
      sw  = op && (ax > ap);
      an  = sw ? ap : ax;
      ad  = sw ? ax : ap;
      neg = x[31] ^ m_p[31];
      v.s = sw;
      if (sw) m_p = x;
      if (ad == 0) begin
        v.c = '0; m_dz = 1'b1; v.lat = 1;
      end else begin
        q = (an << FRAC) / ad;
        if (q > 64'h7FFF_FFFF) q = 64'h7FFF_FFFF;
        v.c = neg ? q[31:0] : (32'h0 - q[31:0]);
        v.lat = 50;
      end
    end
    v.p  = m_p;
    v.dz = m_dz;
  endfunction

  // Called at a negedge; leaves x_valid high so consecutive calls hold it.
  task automatic send(input vec_t v, input bit push);
    int n;
    load = v.ld; operation = v.op; x_in = v.x; x_valid = 1'b1;
    n = 0;
    while (x_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (x_ready !== 1'b1) begin
      n_chk++; n_fail++;
      $display("FAIL ready_timeout: got x_ready=%b expected 1 (cycle %0d)", x_ready, cyc);
    end else if (push) begin
      sb.push_back('{v: v, acc: cyc + 1});
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue_empty", 32'(sb.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (c_valid === 1'b1) begin
      pulses++;
      if (sb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_c_valid: got pulse expected none (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("c_out",    c_out, mon_e.v.c);
        chk("s_out",    {31'b0, s_out}, {31'b0, mon_e.v.s});
        chk("p_out",    p_out, mon_e.v.p);
        chk("div_zero", {31'b0, div_zero}, {31'b0, mon_e.v.dz});
        chk("latency",  32'(cyc - mon_e.acc), 32'(mon_e.v.lat));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    int   p0;
    logic [31:0] rx;

    //          ld   op   x             c             s     p             dz    lat
    tbl.push_back(mk(1'b0, 1'b0, 32'h0001_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1, 1));
    tbl.push_back(mk(1'b1, 1'b0, 32'h0002_0000, 32'h0000_0000, 1'b0, 32'h0002_0000, 1'b0, 1));
    tbl.push_back(mk(1'b0, 1'b1, 32'h0001_0000, 32'hFFFF_8000, 1'b0, 32'h0002_0000, 1'b0, 50));
    tbl.push_back(mk(1'b0, 1'b1, 32'h0004_0000, 32'hFFFF_8000, 1'b1, 32'h0004_0000, 1'b0, 50));
    tbl.push_back(mk(1'b1, 1'b0, 32'h0002_0000, 32'h0000_0000, 1'b0, 32'h0002_0000, 1'b0, 1));
    tbl.push_back(mk(1'b0, 1'b1, 32'hFFFE_0000, 32'h0001_0000, 1'b0, 32'h0002_0000, 1'b0, 50));
    tbl.push_back(mk(1'b0, 1'b0, 32'h0006_0000, 32'hFFFD_0000, 1'b0, 32'h0002_0000, 1'b0, 50));
    tbl.push_back(mk(1'b1, 1'b0, 32'h0000_0001, 32'h0000_0000, 1'b0, 32'h0000_0001, 1'b0, 1));
    tbl.push_back(mk(1'b0, 1'b0, 32'h0001_0000, 32'h8000_0001, 1'b0, 32'h0000_0001, 1'b0, 50));
    tbl.push_back(mk(1'b0, 1'b0, 32'hFFFA_0000, 32'h7FFF_FFFF, 1'b0, 32'h0000_0001, 1'b0, 50));
    tbl.push_back(mk(1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0001, 1'b0, 50));
    tbl.push_back(mk(1'b1, 1'b0, 32'hFFFE_0000, 32'h0000_0000, 1'b0, 32'hFFFE_0000, 1'b0, 1));
    tbl.push_back(mk(1'b0, 1'b0, 32'hFFFF_0000, 32'hFFFF_8000, 1'b0, 32'hFFFE_0000, 1'b0, 50));
    tbl.push_back(mk(1'b1, 1'b0, 32'h0003_0000, 32'h0000_0000, 1'b0, 32'h0003_0000, 1'b0, 1));
    tbl.push_back(mk(1'b0, 1'b0, 32'h0001_0001, 32'hFFFF_AAAB, 1'b0, 32'h0003_0000, 1'b0, 50));
    tbl.push_back(mk(1'b0, 1'b0, 32'hFFFE_FFFF, 32'h0000_5555, 1'b0, 32'h0003_0000, 1'b0, 50));
    tbl.push_back(mk(1'b0, 1'b1, 32'h8000_0000, 32'h0000_0006, 1'b1, 32'h8000_0000, 1'b0, 50));
    tbl.push_back(mk(1'b0, 1'b1, 32'h0002_0000, 32'h0000_0004, 1'b0, 32'h8000_0000, 1'b0, 50));
    tbl.push_back(mk(1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1));
    tbl.push_back(mk(1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1, 1));
    tbl.push_back(mk(1'b0, 1'b0, 32'h0005_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1, 1));
    tbl.push_back(mk(1'b0, 1'b1, 32'hFFFF_0000, 32'h0000_0000, 1'b1, 32'hFFFF_0000, 1'b1, 50));
    tbl.push_back(mk(1'b0, 1'b0, 32'h0002_0000, 32'h0002_0000, 1'b0, 32'hFFFF_0000, 1'b1, 50));

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_c_out",    c_out, 32'h0);
    chk("rst_s_out",    {31'b0, s_out}, 32'h0);
    chk("rst_c_valid",  {31'b0, c_valid}, 32'h0);
    chk("rst_p_out",    p_out, 32'h0);
    chk("rst_div_zero", {31'b0, div_zero}, 32'h0);
    rst = 1'b1;
    #1;
    chk("rst_x_ready", {31'b0, x_ready}, 32'h1);

    // Directed table, x_valid held high between vectors
    for (int i = 0; i < tbl.size(); i++) send(tbl[i], 1'b1);
    x_valid = 1'b0;
    drain();
    @(negedge clk);

    // Reset ten cycles into a division: everything clears, no result appears
    send(mk(1'b0, 1'b1, 32'h0000_8000, 32'h0, 1'b0, 32'h0, 1'b0, 0), 1'b0);
    x_valid = 1'b0;
    repeat (9) @(negedge clk);
    p0 = pulses;
    #2 rst = 1'b0;
    #1;
    chk("abort_c_out",    c_out, 32'h0);
    chk("abort_s_out",    {31'b0, s_out}, 32'h0);
    chk("abort_c_valid",  {31'b0, c_valid}, 32'h0);
    chk("abort_p_out",    p_out, 32'h0);
    chk("abort_div_zero", {31'b0, div_zero}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_x_ready", {31'b0, x_ready}, 32'h1);
    repeat (60) @(negedge clk);
    chk("abort_no_c_valid", 32'(pulses), 32'(p0));

    // Randomized run against the reference model
    for (int i = 0; i < 12; i++) begin
      rx = $urandom;
      rx = rx >> $urandom_range(0, 24);
      if ($urandom_range(0, 1) == 1) rx = 32'h0 - rx;
      model((i == 0) || ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)), rx, v);
      send(v, 1'b1);
    end
    x_valid = 1'b0;
    drain();
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
